// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a shared 8-bit logic unit (AND/OR/XOR/NOT, NZVC flags).
// Optional per-requester grant counters are enabled by defining LU_ARB_PERF_CNT_EN.
module logic_unit_arbiter #(
    parameter int unsigned RESET_PRIO = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [1:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [1:0] req1_sel,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic [7:0] resp_result,
    output logic [3:0] resp_nzvc
`ifdef LU_ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic PRIO_RST = (RESET_PRIO != 0);

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;
    logic [1:0] op_sel_q, op_sel_d;
    logic       op_id_q, op_id_d;
    logic       resp_valid_q, resp_valid_d;
    logic       resp_id_q, resp_id_d;
    logic [7:0] resp_result_q, resp_result_d;
    logic [3:0] resp_nzvc_q, resp_nzvc_d;

    logic       gnt_id;
    logic       accept;
    logic [7:0] lu_result;

    function automatic logic [7:0] lu_op(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] sel);
        case (sel)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic logic [3:0] lu_flags(input logic [7:0] r);
        return {r[7], (r == 8'h00), 1'b0, 1'b0};
    endfunction

    // Ready is gated by rst_n so nothing can handshake while reset is held.
    always_comb begin
        gnt_id     = (req0_valid && req1_valid) ? prio_q : req1_valid;
        req0_ready = rst_n && (state_q == IDLE) && req0_valid && !gnt_id;
        req1_ready = rst_n && (state_q == IDLE) && req1_valid && gnt_id;
        accept     = req0_ready || req1_ready;
    end

    assign lu_result = lu_op(op_a_q, op_b_q, op_sel_q);

    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_sel_d      = op_sel_q;
        op_id_d       = op_id_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_nzvc_d   = resp_nzvc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d   = gnt_id ? req1_a   : req0_a;
                    op_b_d   = gnt_id ? req1_b   : req0_b;
                    op_sel_d = gnt_id ? req1_sel : req0_sel;
                    op_id_d  = gnt_id;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                resp_result_d = lu_result;
                resp_nzvc_d   = lu_flags(lu_result);
                resp_id_d     = op_id_q;
                resp_valid_d  = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    prio_d       = ~resp_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            prio_q        <= PRIO_RST;
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_sel_q      <= '0;
            op_id_q       <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_nzvc_q   <= '0;
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_sel_q      <= op_sel_d;
            op_id_q       <= op_id_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_nzvc_q   <= resp_nzvc_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_nzvc   = resp_nzvc_q;

`ifdef LU_ARB_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Counters saturate at all-ones rather than wrapping.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (req0_ready && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_ONE;
        if (req1_ready && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W != 0);
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: single ops, contention, backpressure, async reset,
// and the grant counters when LU_ARB_PERF_CNT_EN is defined.
module tb_logic_unit_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_sel, req1_sel;
    logic       resp_valid, resp_ready, resp_id;
    logic [7:0] resp_result;
    logic [3:0] resp_nzvc;
`ifdef LU_ARB_PERF_CNT_EN
    logic [1:0] gnt_cnt0, gnt_cnt1;
`endif

    int tests = 0;
    int fails = 0;

    logic_unit_arbiter #(.RESET_PRIO(0), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_nzvc(resp_nzvc)
`ifdef LU_ARB_PERF_CNT_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string tag, input logic v, input logic id,
                            input logic [7:0] r, input logic [3:0] f);
        chk({tag, ".valid"}, {31'b0, resp_valid}, {31'b0, v});
        chk({tag, ".id"}, {31'b0, resp_id}, {31'b0, id});
        chk({tag, ".result"}, {24'b0, resp_result}, {24'b0, r});
        chk({tag, ".nzvc"}, {28'b0, resp_nzvc}, {28'b0, f});
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".rdy0"}, {31'b0, req0_ready}, {31'b0, r0});
        chk({tag, ".rdy1"}, {31'b0, req1_ready}, {31'b0, r1});
    endtask

    initial begin
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h00; req0_sel = 2'b00;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_sel = 2'b00;
        resp_ready = 1'b1;
        #12;
        chk_resp("reset", 1'b0, 1'b0, 8'h00, 4'h0);
        chk_rdy("reset", 1'b0, 1'b0);
        req0_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // AND from req0
        req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h3C; req0_sel = 2'b00;
        #1;
        chk_rdy("and.grant", 1'b1, 1'b0);
        tick();
        req0_valid = 1'b0;
        chk_rdy("and.exec", 1'b0, 1'b0);
        chk("and.exec.valid", {31'b0, resp_valid}, 32'd0);
        tick();
        chk_resp("and", 1'b1, 1'b0, 8'h30, 4'b0000);
        tick();
        chk("and.done", {31'b0, resp_valid}, 32'd0);

        // NOT from req1
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h5A; req1_sel = 2'b11;
        #1;
        chk_rdy("not.grant", 1'b0, 1'b1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk_resp("not", 1'b1, 1'b1, 8'h00, 4'b0100);
        tick();

        // XOR from req0
        req0_valid = 1'b1; req0_a = 8'h80; req0_b = 8'h00; req0_sel = 2'b10;
        tick();
        req0_valid = 1'b0;
        tick();
        chk_resp("xor", 1'b1, 1'b0, 8'h80, 4'b1000);
        tick();

        // Async reset while in EXEC: transaction must vanish
        req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'h0F; req1_sel = 2'b00;
        tick();
        req1_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_resp("rst_exec", 1'b0, 1'b0, 8'h00, 4'h0);
        chk_rdy("rst_exec", 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_exec.noresp", {31'b0, resp_valid}, 32'd0);
        end

        // Contention: both valid continuously, pointer back at 0 after reset
        req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'hF0; req0_sel = 2'b01;
        req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'hAA; req1_sel = 2'b10;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk_rdy($sformatf("cont%0d.grant", k), (k % 2) == 0, (k % 2) == 1);
            tick();
            chk_rdy($sformatf("cont%0d.exec", k), 1'b0, 1'b0);
            tick();
            chk_rdy($sformatf("cont%0d.resp", k), 1'b0, 1'b0);
            if ((k % 2) == 0) chk_resp($sformatf("cont%0d", k), 1'b1, 1'b0, 8'hFF, 4'b1000);
            else              chk_resp($sformatf("cont%0d", k), 1'b1, 1'b1, 8'h00, 4'b0100);
            tick();
        end

        // Backpressure: last response was id 1, so req0 wins next
        resp_ready = 1'b0;
        req0_a = 8'hFF; req0_b = 8'h0F; req0_sel = 2'b00;
        #1;
        chk_rdy("bp.grant", 1'b1, 1'b0);
        tick();
        tick();
        chk_resp("bp.first", 1'b1, 1'b0, 8'h0F, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_resp($sformatf("bp.hold%0d", i), 1'b1, 1'b0, 8'h0F, 4'b0000);
            chk_rdy($sformatf("bp.hold%0d", i), 1'b0, 1'b0);
        end
        resp_ready = 1'b1;
        tick();
        chk("bp.release.valid", {31'b0, resp_valid}, 32'd0);
        chk_rdy("bp.regrant", 1'b0, 1'b1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

`ifdef LU_ARB_PERF_CNT_EN
        rst_n = 1'b0;
        #1;
        chk("cnt.reset0", {30'b0, gnt_cnt0}, 32'd0);
        chk("cnt.reset1", {30'b0, gnt_cnt1}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req0_valid = 1'b1;
            tick();
            req0_valid = 1'b0;
            chk($sformatf("cnt0.%0d", k), {30'b0, gnt_cnt0}, {30'b0, exp_cnt[k]});
            chk($sformatf("cnt1.%0d", k), {30'b0, gnt_cnt1}, 32'd0);
            tick();
            tick();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
